// File: rtl/armaria_pkg.sv
// Shared ARMAria definitions: fetch FSM encoding and core width / reset-vector defaults.
package armaria_pkg;

  localparam int unsigned DEFAULT_INSTRUCTION_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH     = 32;
  localparam logic [63:0] DEFAULT_RESET_VECTOR      = 64'd0;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/prefetch_queue.sv
// Circular instruction queue holding each word together with its fetch address.
module prefetch_queue
  import armaria_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic [ADDR_WIDTH-1:0]        head_addr,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic                  pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)   tail_d = tail_q + PTR_W'(1);
      if (pop_ok) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      data_mem[tail_q] <= push_data;
      addr_mem[tail_q] <= push_addr;
    end
  end

  assign valid     = (count_q != '0);
  assign count     = count_q;
  assign head_data = valid ? data_mem[head_q] : '0;
  assign head_addr = valid ? addr_mem[head_q] : '0;

endmodule

// File: rtl/instruction_prefetcher.sv
// Sequential instruction prefetcher with branch redirect; stale in-flight responses are
// counted out and dropped while in FLUSH.
module instruction_prefetcher
  import armaria_pkg::*;
#(
  parameter int unsigned              INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int unsigned              ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned              QUEUE_DEPTH       = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         mem_request,
  output logic [ADDRESS_WIDTH-1:0]     mem_address,
  input  logic                         mem_accept,
  input  logic                         mem_response_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic [ADDRESS_WIDTH-1:0]     instruction_address,
  output logic                         instruction_valid,
  input  logic                         consume,
  input  logic                         should_take_branch,
  input  logic [ADDRESS_WIDTH-1:0]     branch_target
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e           state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0]       discard_q, discard_d;
  logic                   running_q, running_d;
  logic                   issue, response_live, push, pop;
  logic [CNT_W-1:0]       queue_count;
  logic [OCC_W-1:0]       occupancy;

  assign issue         = mem_request && mem_accept;
  assign response_live = mem_response_valid && (outstanding_q != '0);
  assign push          = response_live && (state_q == FETCH) && !should_take_branch;
  assign pop           = consume && instruction_valid && !should_take_branch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_ptr_q   <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_ptr_q   <= fetch_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      running_q     <= running_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_ptr_d   = fetch_ptr_q;
    discard_d     = discard_q;
    running_d     = 1'b1;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(response_live);
    if (issue) fetch_ptr_d = fetch_ptr_q + ADDRESS_WIDTH'(1);
    case (state_q)
      FETCH: begin
        // Anything still in flight after this edge (including a same-cycle issue) is stale.
        if (should_take_branch) begin
          fetch_ptr_d = branch_target;
          discard_d   = outstanding_d;
          state_d     = (outstanding_d != '0) ? FLUSH : FETCH;
        end
      end
      FLUSH: begin
        if (response_live) discard_d = discard_q - CNT_W'(1);
        if (should_take_branch) fetch_ptr_d = branch_target;
        if (discard_d == '0) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    occupancy   = OCC_W'(queue_count) + OCC_W'(outstanding_q);
    mem_request = running_q && (state_q == FETCH) && (occupancy < OCC_W'(QUEUE_DEPTH));
  end

  assign mem_address = fetch_ptr_q;

  prefetch_queue #(
    .DATA_WIDTH (INSTRUCTION_WIDTH),
    .ADDR_WIDTH (ADDRESS_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (mem_data),
    .push_addr (fetch_ptr_q - ADDRESS_WIDTH'(outstanding_q)),
    .pop       (pop),
    .flush     (should_take_branch),
    .head_data (Instruction),
    .head_addr (instruction_address),
    .valid     (instruction_valid),
    .count     (queue_count)
  );

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Directed per-cycle vector table for the prefetcher plus a hand-written mid-cycle reset sequence.
module tb_instruction_prefetcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_accept = 1'b0;
  logic        mem_response_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] Instruction;
  logic [31:0] instruction_address;
  logic        instruction_valid;
  logic        consume = 1'b0;
  logic        should_take_branch = 1'b0;
  logic [31:0] branch_target = '0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  instruction_prefetcher dut (
    .clock               (clock),
    .reset               (reset),
    .mem_request         (mem_request),
    .mem_address         (mem_address),
    .mem_accept          (mem_accept),
    .mem_response_valid  (mem_response_valid),
    .mem_data            (mem_data),
    .Instruction         (Instruction),
    .instruction_address (instruction_address),
    .instruction_valid   (instruction_valid),
    .consume             (consume),
    .should_take_branch  (should_take_branch),
    .branch_target       (branch_target)
  );

  typedef struct {
    logic        rst;
    logic        acc;
    logic        rv;
    logic [15:0] rd;
    logic        cons;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic [31:0] iad;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic a, input logic rv, input logic [15:0] rd,
                              input logic c, input logic b, input logic [31:0] t,
                              input logic req, input logic [31:0] ad, input logic v,
                              input logic [15:0] ins, input logic [31:0] ia);
    vec_t e;
    e.rst = r; e.acc = a; e.rv = rv; e.rd = rd; e.cons = c; e.br = b; e.tgt = t;
    e.req = req; e.addr = ad; e.vld = v; e.ins = ins; e.iad = ia;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int edges;
    logic found;

    // rst acc rv data cons br target | req addr valid instr iaddr
    // Streaming: accept always, 1-cycle latency, consume always.
    add(0,1,0,16'h0,1,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,1,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,1,0,32'h0,        1,32'h0,0,16'h0,32'h0);
    add(1,1,1,16'h1000,1,0,32'h0,     1,32'h1,0,16'h0,32'h0);
    add(1,1,1,16'h1001,1,0,32'h0,     1,32'h2,1,16'h1000,32'h0);
    add(1,1,1,16'h1002,1,0,32'h0,     1,32'h3,1,16'h1001,32'h1);
    add(1,1,1,16'h1003,1,0,32'h0,     1,32'h4,1,16'h1002,32'h2);
    add(1,0,1,16'h1004,1,0,32'h0,     1,32'h5,1,16'h1003,32'h3);
    add(1,0,0,16'h0,0,0,32'h0,        1,32'h5,1,16'h1004,32'h4);
    // No consume: fill to depth, request held low, push+pop at depth-1, drain.
    add(0,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h0,0,16'h0,32'h0);
    add(1,1,1,16'h1000,0,0,32'h0,     1,32'h1,0,16'h0,32'h0);
    add(1,1,1,16'h1001,0,0,32'h0,     1,32'h2,1,16'h1000,32'h0);
    add(1,1,1,16'h1002,0,0,32'h0,     1,32'h3,1,16'h1000,32'h0);
    add(1,1,1,16'h1003,0,0,32'h0,     0,32'h4,1,16'h1000,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h4,1,16'h1000,32'h0);
    add(1,1,0,16'h0,1,0,32'h0,        0,32'h4,1,16'h1000,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h4,1,16'h1001,32'h1);
    add(1,0,1,16'h1004,1,0,32'h0,     0,32'h5,1,16'h1001,32'h1);
    add(1,0,0,16'h0,1,0,32'h0,        1,32'h5,1,16'h1002,32'h2);
    add(1,0,0,16'h0,1,0,32'h0,        1,32'h5,1,16'h1003,32'h3);
    add(1,0,0,16'h0,1,0,32'h0,        1,32'h5,1,16'h1004,32'h4);
    add(1,0,0,16'h0,0,0,32'h0,        1,32'h5,0,16'h0,32'h0);
    // Branches: two outstanding -> 0x40; re-branch in FLUSH 0x60/0x80/0x90; wrap at 0xFFFFFFFF.
    add(0,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h1,0,16'h0,32'h0);
    add(1,0,0,16'h0,0,1,32'h40,       1,32'h2,0,16'h0,32'h0);
    add(1,1,1,16'h1000,0,0,32'h0,     0,32'h40,0,16'h0,32'h0);
    add(1,1,1,16'h1001,0,0,32'h0,     0,32'h40,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h40,0,16'h0,32'h0);
    add(1,0,1,16'h1040,0,0,32'h0,     1,32'h41,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h41,1,16'h1040,32'h40);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h42,1,16'h1040,32'h40);
    add(1,0,1,16'h1041,1,1,32'h60,    1,32'h43,1,16'h1040,32'h40);
    add(1,0,0,16'h0,0,1,32'h80,       0,32'h60,0,16'h0,32'h0);
    add(1,0,0,16'h0,0,1,32'h90,       0,32'h80,0,16'h0,32'h0);
    add(1,0,1,16'h1042,0,0,32'h0,     0,32'h90,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h90,0,16'h0,32'h0);
    add(1,0,1,16'h1090,0,0,32'h0,     1,32'h91,0,16'h0,32'h0);
    add(1,0,0,16'h0,0,1,32'hFFFFFFFF, 1,32'h91,1,16'h1090,32'h90);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'hFFFFFFFF,0,16'h0,32'h0);
    add(1,0,1,16'hBEEF,0,0,32'h0,     1,32'h0,0,16'h0,32'h0);
    add(1,0,1,16'hDEAD,0,0,32'h0,     1,32'h0,1,16'hBEEF,32'hFFFFFFFF);
    add(1,0,0,16'h0,1,0,32'h0,        1,32'h0,1,16'hBEEF,32'hFFFFFFFF);
    add(1,0,0,16'h0,0,0,32'h0,        1,32'h0,0,16'h0,32'h0);
    // Reset with 3 queued and 1 outstanding, then restart at the reset vector.
    add(0,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h0,0,16'h0,32'h0);
    add(1,1,1,16'h1000,0,0,32'h0,     1,32'h1,0,16'h0,32'h0);
    add(1,1,1,16'h1001,0,0,32'h0,     1,32'h2,1,16'h1000,32'h0);
    add(1,0,1,16'h1002,0,0,32'h0,     1,32'h3,1,16'h1000,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h3,1,16'h1000,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h4,1,16'h1000,32'h0);
    add(0,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        0,32'h0,0,16'h0,32'h0);
    add(1,1,0,16'h0,0,0,32'h0,        1,32'h0,0,16'h0,32'h0);

    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      reset              = vecs[i].rst;
      mem_accept         = vecs[i].acc;
      mem_response_valid = vecs[i].rv;
      mem_data           = vecs[i].rd;
      consume            = vecs[i].cons;
      should_take_branch = vecs[i].br;
      branch_target      = vecs[i].tgt;
      #1;
      check("mem_request", i, 32'(mem_request), 32'(vecs[i].req));
      check("mem_address", i, mem_address, vecs[i].addr);
      check("instruction_valid", i, 32'(instruction_valid), 32'(vecs[i].vld));
      if (vecs[i].vld || !vecs[i].rst) begin
        check("Instruction", i, 32'(Instruction), 32'(vecs[i].ins));
        check("instruction_address", i, instruction_address, vecs[i].iad);
      end
      $display("row %0d rst=%b req=%b addr=%h valid=%b instr=%h iaddr=%h",
               i, reset, mem_request, mem_address, instruction_valid, Instruction, instruction_address);
    end

    // Address 0 was issued at the last table edge; its response lands, then reset strikes mid-cycle.
    @(negedge clock);
    mem_accept         = 1'b0;
    mem_response_valid = 1'b1;
    mem_data           = 16'h1000;
    consume            = 1'b0;
    should_take_branch = 1'b0;
    @(posedge clock);
    #1;
    check("pre_reset_valid", -1, 32'(instruction_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_valid", -1, 32'(instruction_valid), 32'd0);
    check("async_reset_request", -1, 32'(mem_request), 32'd0);
    check("async_reset_instr", -1, 32'(Instruction), 32'd0);
    check("async_reset_iaddr", -1, instruction_address, 32'd0);
    mem_response_valid = 1'b0;
    @(negedge clock);
    reset      = 1'b1;
    mem_accept = 1'b1;
    #1;
    check("release_request", -1, 32'(mem_request), 32'd0);
    edges = 0;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(posedge clock);
      #1;
      edges++;
      if (mem_request) found = 1'b1;
    end
    check("first_request_edges", -1, 32'(edges), 32'd1);
    check("first_request_addr", -1, mem_address, 32'd0);
    $display("reset sequence: first request after %0d edge(s) at %h", edges, mem_address);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_prefetcher.md
INSTRUCTION_PREFETCHER -- requirements
Module: instruction_prefetcher

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, width of one instruction word.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, instruction address width, counted in instruction-word units.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-005 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port mem_request  output  1  read request to instruction memory.
REQ-008 SHALL have port mem_address  output  ADDRESS_WIDTH  address of requested word.
REQ-009 SHALL have port mem_accept  input  1  memory takes request this cycle (request AND accept = issue).
REQ-010 SHALL have port mem_response_valid  input  1  returned word valid, responses in issue order.
REQ-011 SHALL have port mem_data  input  INSTRUCTION_WIDTH  returned word.
REQ-012 SHALL have port Instruction  output  INSTRUCTION_WIDTH  head-of-queue word fed to Control.
REQ-013 SHALL have port instruction_address  output  ADDRESS_WIDTH  address of Instruction.
REQ-014 SHALL have port instruction_valid  output  1  queue non-empty.
REQ-015 SHALL have port consume  input  1  Control retires head this cycle (ignored when not valid).
REQ-016 SHALL have port should_take_branch  input  1  redirect: flush and refetch.
REQ-017 SHALL have port branch_target  input  ADDRESS_WIDTH  redirect address.

Function
REQ-018 SHALL issue sequential addresses: after each issue, fetch pointer += 1, wrapping modulo 2^ADDRESS_WIDTH.
REQ-019 SHALL assert mem_request only when queue occupancy + outstanding requests < QUEUE_DEPTH and state is FETCH; no response ever finds the queue full.
REQ-020 SHALL hold mem_address stable while mem_request is high and mem_accept low.
REQ-021 SHALL write each non-discarded response into the queue tail with its address the cycle it arrives; it becomes visible on Instruction the following cycle earliest.
REQ-022 SHALL pop head on consume AND instruction_valid; simultaneous push and pop keeps occupancy unchanged, including at occupancy QUEUE_DEPTH-1 and 0.
REQ-023 SHALL implement states FETCH and FLUSH.
REQ-024 FETCH: on should_take_branch, empty queue same edge, set fetch pointer to branch_target, record outstanding count as discard count; go to FLUSH if nonzero outstanding after this edge, else stay FETCH.
REQ-025 FLUSH: mem_request low, every response decrements discard count and is dropped; at zero return to FETCH.
REQ-026 SHALL treat should_take_branch in FLUSH as a new redirect: update fetch pointer, keep discarding, no double count.
REQ-027 SHALL give should_take_branch priority over consume and over any response in the same cycle (response dropped if it was outstanding before the branch).
REQ-028 SHALL drive instruction_valid low in the cycle after a branch until the first target word arrives.
REQ-029 Outstanding counter width SHALL cover 0..QUEUE_DEPTH; a response with zero outstanding SHALL be ignored.

Reset
REQ-030 On reset low, SHALL immediately set: state FETCH, fetch pointer RESET_VECTOR, queue empty, outstanding 0, discard 0, mem_request 0, instruction_valid 0, Instruction 0, instruction_address 0.
REQ-031 Reset mid-transaction SHALL abandon outstanding requests; memory is reset by the same signal.
REQ-032 First mem_request SHALL assert the first clock edge after reset deasserts.

Structure
REQ-033 State encoding, RESET_VECTOR default, and INSTRUCTION_WIDTH/ADDRESS_WIDTH defaults SHALL live in the shared ARMAria package.
REQ-034 Queue SHALL be a sub-module prefetch_queue (data+address storage, head/tail pointers, count, push/pop/flush).

Verification
REQ-035 Reset, mem_accept=1, 1-cycle response latency, consume=1 always: addresses 0,1,2,3 issued back-to-back, Instruction follows at one word per cycle.
REQ-036 consume=0, mem_accept=1: exactly 4 requests issued, queue holds words from 0..3, mem_request stays low until a consume.
REQ-037 Two requests outstanding, should_take_branch=1 with branch_target=0x40: both responses dropped, next issued address 0x40, first valid Instruction has address 0x40.
REQ-038 Branch to 0x80 in FLUSH with one response still pending, then branch to 0x90: response dropped, next issue 0x90.
REQ-039 Fetch pointer 0xFFFFFFFF issues then wraps: next mem_address 0x00000000.
REQ-040 Reset asserted with 3 queued and 1 outstanding: instruction_valid 0 immediately; after release, first request at RESET_VECTOR.
